mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-side memory port between three requesters: the UART program loader, the D-cache and the I-cache.
- Sequences line refills as fixed-length bursts over a fixed-latency BRAM port. Sequences D-cache single-word writes and UART word writes.
- Sits between the cache controllers/UART loader and the memory block. Drives its address, write-data and write-enable and consumes its read data.

Parameters:
DATA_W, 32, data and address width (byte addresses)
BURST, 4, words per cache line refill (power of two, >=2)
MEM_LAT, 2, cycles from address presented to mem_rdata valid (>=1)
STARVE_MAX, 2, consecutive D-cache wins allowed while I-cache is waiting

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
uart_req  in  1  UART word-write request
uart_addr  in  DATA_W  UART write address
uart_wdata  in  DATA_W  UART write data
uart_ack  out  1  pulse: UART write performed
dc_req  in  1  D-cache request
dc_we  in  1  1 = single-word write, 0 = line refill
dc_addr  in  DATA_W  D-cache address
dc_wdata  in  DATA_W  D-cache write data
ic_req  in  1  I-cache line refill request
ic_addr  in  DATA_W  I-cache miss address
rdata  out  DATA_W  refill word (shared by both caches)
rword  out  log2(BURST)  index of refill word within line
dc_rvalid, ic_rvalid  out  1 each  refill word valid for that cache
dc_done, ic_done  out  1 each  pulse: transaction complete
mem_addr  out  DATA_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data
busy  out  1  arbiter not in IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - All outputs are 0.
  - FSM returns to IDLE.
  - Issue and return counters clear.
  - Read-valid shift pipeline clears: in-flight reads are discarded and no rvalid/done follows.
- States: IDLE, UART_WR, DC_WR, IC_RD, DC_RD, DRAIN.
- Arbitration in IDLE, registered; the winner's state is entered next cycle. Priority order:
  - uart_req always wins.
  - else if ic_req and starve_cnt==STARVE_MAX -> I-cache wins.
  - else dc_req wins.
  - else ic_req wins.
- starve_cnt:
  - Increments on a D-cache win while ic_req is high, saturating at STARVE_MAX.
  - Clears on an I-cache win, or when ic_req is low at arbitration.
- UART_WR / DC_WR (one cycle):
  - mem_addr = {addr[DATA_W-1:2],2'b00}, mem_wdata = wdata, mem_we = 1.
  - uart_ack or dc_done pulses in the same cycle.
  - Next state is IDLE.
- IC_RD / DC_RD burst:
  - base = addr with the low log2(BURST)+2 bits zeroed.
  - Issue cycles i=0..BURST-1 are consecutive, with mem_addr = base + 4*i and mem_we = 0.
  - Word i returns MEM_LAT cycles after its issue: rdata = mem_rdata, rword = i, and the matching rvalid is high for 1 cycle.
  - The matching done pulses together with the rvalid of word BURST-1.
  - After the last issue, the FSM enters DRAIN until the final return, then goes to IDLE.
  - Latency:
    - Request sampled at cycle T.
    - First rvalid at T+1+MEM_LAT.
    - done at T+BURST+MEM_LAT.
    - Next arbitration at T+BURST+MEM_LAT+1.
- Request hold and addressing rules:
  - Requesters hold req and addr stable until ack/done.
  - The arbiter latches addr/wdata/we at grant, so later changes are ignored.
  - req dropping mid-transaction does not abort it.
- Idle outputs: outside write cycles mem_we = 0. In IDLE mem_addr holds its last value.
- Simultaneous events: all three requesting in IDLE -> UART is served first, then the D/I order follows starve_cnt.
- Address wrap: base+4*i is computed modulo 2^DATA_W; there is no carry out of the line.

Test Plan:
- Reset, then ic_req=1, ic_addr=0x0000_0014, BURST=4, MEM_LAT=2 -> mem_addr 0x10, 0x14, 0x18, 0x1C on cycles T+1..T+4; ic_rvalid on T+3..T+6 with rword 0..3; ic_done at T+6; busy low at T+7.
- uart_req=1, addr=0x100, wdata=0xDEADBEEF -> one cycle with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, uart_ack=1; no rvalid.
- uart_req, dc_req (read) and ic_req asserted together -> order is UART write, D-cache refill, I-cache refill; dc_rvalid never overlaps ic_rvalid.
- dc_req held continuously with ic_req held, STARVE_MAX=2 -> grants D, D, I, D, D, I.
- rst asserted during word 2 of an I-cache burst -> outputs 0 immediately; no further ic_rvalid/ic_done; a new dc_we=1 write to 0x40 after reset completes normally with dc_done.
- dc_addr=0xFFFF_FFF4 refill -> mem_addr 0xFFFF_FFF0..0xFFFF_FFFC, no wrap beyond the line; dc_done at T+BURST+MEM_LAT.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port among UART writes, D-cache writes/refills and I-cache refills; writes take 1 cycle after grant.
// Refills: first word at grant+1+MEM_LAT, done at grant+BURST+MEM_LAT; requesters hold req until ack/done (no backpressure).
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int BURST      = 4,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_req,
    input  logic [DATA_W-1:0]          uart_addr,
    input  logic [DATA_W-1:0]          uart_wdata,
    output logic                       uart_ack,
    input  logic                       dc_req,
    input  logic                       dc_we,
    input  logic [DATA_W-1:0]          dc_addr,
    input  logic [DATA_W-1:0]          dc_wdata,
    input  logic                       ic_req,
    input  logic [DATA_W-1:0]          ic_addr,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(BURST)-1:0]   rword,
    output logic                       dc_rvalid,
    output logic                       ic_rvalid,
    output logic                       dc_done,
    output logic                       ic_done,
    output logic [DATA_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy
);
    localparam int IW       = $clog2(BURST);
    localparam int LINE_LSB = IW + 2;
    localparam int SW       = $clog2(STARVE_MAX + 2);
    localparam logic [DATA_W-1:0] WORD_MASK  = {{(DATA_W-2){1'b1}}, 2'b00};
    localparam logic [DATA_W-1:0] LINE_MASK  = {{(DATA_W-LINE_LSB){1'b1}}, {LINE_LSB{1'b0}}};
    localparam logic [IW-1:0]     LAST_WORD  = IW'(BURST - 1);
    localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, UART_WR, DC_WR, IC_RD, DC_RD, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       ret_q, ret_d;
    logic [MEM_LAT-1:0]  rv_q, rv_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                owner_dc_q, owner_dc_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                uart_ack_q, uart_ack_d;
    logic                dc_wdone_q, dc_wdone_d;
    logic                issue;
    logic                ret_vld;
    logic                ret_last;

    assign ret_vld  = rv_q[MEM_LAT-1];
    assign ret_last = ret_vld && (ret_q == LAST_WORD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        starve_d    = starve_q;
        owner_dc_d  = owner_dc_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        uart_ack_d  = 1'b0;
        dc_wdone_d  = 1'b0;
        issue       = 1'b0;

        if (ret_vld) begin
            ret_d = ret_q + IW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!ic_req) begin
                    starve_d = '0;
                end
                if (uart_req) begin
                    state_d     = UART_WR;
                    mem_addr_d  = uart_addr & WORD_MASK;
                    mem_wdata_d = uart_wdata;
                    mem_we_d    = 1'b1;
                    uart_ack_d  = 1'b1;
                end else if (ic_req && (starve_q == STARVE_TOP)) begin
                    state_d    = IC_RD;
                    owner_dc_d = 1'b0;
                    mem_addr_d = ic_addr & LINE_MASK;
                    cnt_d      = '0;
                    starve_d   = '0;
                end else if (dc_req) begin
                    // ic_req high here implies starve_q < STARVE_TOP
                    if (ic_req) begin
                        starve_d = starve_q + SW'(1);
                    end
                    if (dc_we) begin
                        state_d     = DC_WR;
                        mem_addr_d  = dc_addr & WORD_MASK;
                        mem_wdata_d = dc_wdata;
                        mem_we_d    = 1'b1;
                        dc_wdone_d  = 1'b1;
                    end else begin
                        state_d    = DC_RD;
                        owner_dc_d = 1'b1;
                        mem_addr_d = dc_addr & LINE_MASK;
                        cnt_d      = '0;
                    end
                end else if (ic_req) begin
                    state_d    = IC_RD;
                    owner_dc_d = 1'b0;
                    mem_addr_d = ic_addr & LINE_MASK;
                    cnt_d      = '0;
                    starve_d   = '0;
                end
            end
            UART_WR, DC_WR: begin
                state_d = IDLE;
            end
            IC_RD, DC_RD: begin
                issue = 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + IW'(1);
                    mem_addr_d = mem_addr_q + DATA_W'(4);
                end
            end
            DRAIN: begin
                if (ret_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Valid bit travels MEM_LAT stages, matching the BRAM read latency
        rv_d    = rv_q << 1;
        rv_d[0] = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ret_q       <= '0;
            rv_q        <= '0;
            starve_q    <= '0;
            owner_dc_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            uart_ack_q  <= 1'b0;
            dc_wdone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ret_q       <= ret_d;
            rv_q        <= rv_d;
            starve_q    <= starve_d;
            owner_dc_q  <= owner_dc_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            uart_ack_q  <= uart_ack_d;
            dc_wdone_q  <= dc_wdone_d;
        end
    end

    assign rdata     = ret_vld ? mem_rdata : '0;
    assign rword     = ret_q;
    assign dc_rvalid = ret_vld && owner_dc_q;
    assign ic_rvalid = ret_vld && !owner_dc_q;
    assign dc_done   = dc_wdone_q || (ret_last && owner_dc_q);
    assign ic_done   = ret_last && !owner_dc_q;
    assign uart_ack  = uart_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a BRAM model returns addr^KEY, so read data also proves the issued address.
module tb_mem_port_arbiter;
    localparam int DATA_W     = 32;
    localparam int BURST      = 4;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;
    localparam logic [31:0] KEY = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_req, dc_req, dc_we, ic_req;
    logic [31:0] uart_addr, uart_wdata, dc_addr, dc_wdata, ic_addr;
    logic        uart_ack, dc_rvalid, ic_rvalid, dc_done, ic_done, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  rword;

    typedef struct {logic dc; logic [1:0] w; logic [31:0] d; logic last;} rd_t;
    typedef struct {logic u; logic [31:0] a; logic [31:0] d;} wr_t;
    rd_t rq[$];
    wr_t wq[$];
    rd_t r;
    wr_t w;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int first_rv_cyc = -1, done_cyc = -1;
    int stray = 0, overlap = 0, unexp = 0;
    logic [31:0] ap [MEM_LAT];

    mem_port_arbiter #(.DATA_W(DATA_W), .BURST(BURST), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_ack(uart_ack),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .rdata(rdata), .rword(rword), .dc_rvalid(dc_rvalid), .ic_rvalid(ic_rvalid),
        .dc_done(dc_done), .ic_done(ic_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        ap[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) ap[i] <= ap[i-1];
    end
    assign mem_rdata = ap[MEM_LAT-1] ^ KEY;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_line(input logic dc, input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'hF;
        for (int i = 0; i < BURST; i++)
            rq.push_back('{dc, 2'(i), (base + 32'(4*i)) ^ KEY, i == BURST-1});
    endtask

    task automatic push_wr(input logic u, input logic [31:0] addr, input logic [31:0] data);
        wq.push_back('{u, addr & ~32'h3, data});
    endtask

    // which: 0 uart_ack, 1 dc_done, 2 ic_done; returns at the negedge of the pulse
    task automatic wait_done(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? uart_ack : (which == 1) ? dc_done : ic_done;
        end
    endtask

    task automatic settle(input string tag);
        repeat (MEM_LAT + 2) @(negedge clk);
        chk(tag, {29'd0, busy, rq.size() != 0, wq.size() != 0}, 32'd0);
    endtask

    task automatic refill_timed(input logic dc, input logic [31:0] addr);
        int  t0;
        bit  seen;
        logic [31:0] base;
        base = addr & ~32'hF;
        push_line(dc, addr);
        @(posedge clk); #1;
        if (dc) begin dc_req = 1'b1; dc_we = 1'b0; dc_addr = addr; end
        else begin ic_req = 1'b1; ic_addr = addr; end
        t0 = cyc;
        @(negedge clk);
        for (int i = 0; i < BURST; i++) begin
            @(negedge clk);
            chk("iss_addr", mem_addr, base + 32'(4*i));
            chk("iss_we", {31'd0, mem_we}, 32'd0);
        end
        wait_done(dc ? 1 : 2, 20, seen);
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        if (dc) dc_req = 1'b0; else ic_req = 1'b0;
        chk("first_rv_cyc", first_rv_cyc, t0 + 1 + MEM_LAT);
        chk("done_cyc", done_cyc, t0 + BURST + MEM_LAT);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wq.size() == 0) unexp++;
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_addr, w.a);
                    chk("wr_data", mem_wdata, w.d);
                    chk("wr_ack", {30'd0, uart_ack, dc_done}, w.u ? 32'd2 : 32'd1);
                end
            end
            if (dc_rvalid && ic_rvalid) overlap++;
            if (dc_rvalid || ic_rvalid) begin
                if (rq.size() == 0) unexp++;
                else begin
                    r = rq.pop_front();
                    chk("rv_owner", {30'd0, dc_rvalid, ic_rvalid}, r.dc ? 32'd2 : 32'd1);
                    chk("rv_word", {30'd0, rword}, {30'd0, r.w});
                    chk("rv_data", rdata, r.d);
                    chk("rv_done", {30'd0, dc_done, ic_done}, !r.last ? 32'd0 : r.dc ? 32'd2 : 32'd1);
                    if (r.w == 2'd0) first_rv_cyc = cyc;
                    if (r.last) done_cyc = cyc;
                end
            end else if (!mem_we && (dc_done || ic_done || uart_ack)) stray++;
            if (ic_done && !ic_rvalid) stray++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit s0, s1, s2;
        int ndone;
        rst = 1'b1;
        uart_req = 0; dc_req = 0; dc_we = 0; ic_req = 0;
        uart_addr = 0; uart_wdata = 0; dc_addr = 0; dc_wdata = 0; ic_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {25'd0, uart_ack, dc_rvalid, ic_rvalid, dc_done, ic_done, mem_we, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rword", {30'd0, rword}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // I-cache refill with cycle-exact timing
        refill_timed(1'b0, 32'h0000_0014);
        settle("idle_ic");

        // UART word write
        push_wr(1'b1, 32'h100, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        uart_req = 1'b1; uart_addr = 32'h100; uart_wdata = 32'hDEAD_BEEF;
        wait_done(0, 10, s0);
        chk("uart_seen", {31'd0, s0}, 32'd1);
        @(posedge clk); #1 uart_req = 1'b0;
        settle("idle_uart");

        // All three at once: UART, then D refill, then I refill
        push_wr(1'b1, 32'h200, 32'hCAFE_0001);
        push_line(1'b1, 32'h1000);
        push_line(1'b0, 32'h2000);
        @(posedge clk); #1;
        uart_req = 1'b1; uart_addr = 32'h200; uart_wdata = 32'hCAFE_0001;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h1000;
        ic_req = 1'b1; ic_addr = 32'h2000;
        fork
            begin wait_done(0, 40, s0); chk("all_u_seen", {31'd0, s0}, 32'd1); @(posedge clk); #1 uart_req = 1'b0; end
            begin wait_done(1, 40, s1); chk("all_d_seen", {31'd0, s1}, 32'd1); @(posedge clk); #1 dc_req = 1'b0; end
            begin wait_done(2, 60, s2); chk("all_i_seen", {31'd0, s2}, 32'd1); @(posedge clk); #1 ic_req = 1'b0; end
        join
        settle("idle_all");

        // Starvation limit: D, D, I, D, D, I
        push_line(1'b1, 32'h3000); push_line(1'b1, 32'h3000); push_line(1'b0, 32'h4000);
        push_line(1'b1, 32'h3000); push_line(1'b1, 32'h3000); push_line(1'b0, 32'h4000);
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000;
        ic_req = 1'b1; ic_addr = 32'h4000;
        ndone = 0;
        for (int i = 0; i < 200 && ndone < 2; i++) begin
            @(negedge clk);
            if (ic_done) ndone++;
        end
        chk("starve_ic_done", ndone, 2);
        @(posedge clk); #1 dc_req = 1'b0; ic_req = 1'b0;
        settle("idle_starve");

        // Reset in the middle of an I-cache burst
        push_line(1'b0, 32'h500);
        @(posedge clk); #1 ic_req = 1'b1; ic_addr = 32'h500;
        s0 = 1'b0;
        for (int i = 0; i < 20 && !s0; i++) begin
            @(negedge clk);
            s0 = ic_rvalid && (rword == 2'd1);
        end
        chk("rst_mid_seen", {31'd0, s0}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_mid_flags", {25'd0, uart_ack, dc_rvalid, ic_rvalid, dc_done, ic_done, mem_we, busy}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        rq.delete();
        ic_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_post_busy", {31'd0, busy}, 32'd0);
        push_wr(1'b0, 32'h40, 32'h1234_5678);
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h40; dc_wdata = 32'h1234_5678;
        wait_done(1, 10, s1);
        chk("rst_dcw_seen", {31'd0, s1}, 32'd1);
        @(posedge clk); #1 dc_req = 1'b0; dc_we = 1'b0;
        settle("idle_dcw");

        // Refill at the top of the address space
        refill_timed(1'b1, 32'hFFFF_FFF4);
        settle("idle_wrap");

        chk("stray_pulses", stray, 0);
        chk("rv_overlap", overlap, 0);
        chk("unexpected", unexp, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
